// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 fetch stage and its IF/ID register.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // ADD XZR,XZR,XZR: decode sees a harmless instruction in every bubble
  localparam logic [31:0] NOP_INSTR = 32'h8B1F03FF;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads on enable, flush turns the entry into a bubble
// while keeping the last pc so decode always sees a consistent tuple.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [63:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic        d_valid,
  output logic [63:0] pc,
  output logic [31:0] instr,
  output logic        valid
);

  ifid_t r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '{pc: 64'h0, instr: NOP, valid: 1'b0};
    end else if (en) begin
      if (flush) begin
        r.valid <= 1'b0;
        r.instr <= NOP;
      end else begin
        r <= '{pc: d_pc, instr: d_instr, valid: d_valid};
      end
    end
  end

  assign pc    = r.pc;
  assign instr = r.instr;
  assign valid = r.valid;

endmodule

// File: rtl/fetch_ifid.sv
// LEGv8 instruction fetch: PC, req/ack memory handshake with a one-word skid
// buffer for decode stalls, branch redirect/flush, and the IF/ID register.
module fetch_ifid #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d
);

  import fetch_pkg::*;

  fetch_state_t state, state_nxt;
  logic [63:0]  pc, pc_nxt;
  logic [63:0]  drop_addr, drop_addr_nxt;
  logic [31:0]  skid, skid_nxt;
  logic         fetch_en;
  logic         accept;
  logic         ld;
  logic [63:0]  ifid_pc;
  logic [31:0]  ifid_instr;

  // fetch_en delays the first request to the cycle after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= REQ;
      pc        <= RESET_PC;
      drop_addr <= 64'h0;
      skid      <= NOP_INSTR;
      fetch_en  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
      skid      <= skid_nxt;
      fetch_en  <= 1'b1;
    end
  end

  assign imem_req  = fetch_en && (state != HOLD);
  // a stale request keeps its address while pc already points at the target
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign accept    = imem_req && imem_ack;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    skid_nxt      = skid;
    ld            = 1'b0;
    ifid_pc       = pc;
    ifid_instr    = imem_rdata;
    if (br_taken) begin
      pc_nxt   = word_align(br_target);
      skid_nxt = NOP_INSTR;
      if (imem_req && !accept) begin
        state_nxt = DROP;
        if (state != DROP) drop_addr_nxt = pc;
      end else begin
        state_nxt = REQ;
      end
    end else begin
      case (state)
        REQ: begin
          if (accept) begin
            pc_nxt = pc + 64'd4;
            if (stall_d) begin
              skid_nxt  = imem_rdata;
              state_nxt = HOLD;
            end else begin
              ld = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stall_d) begin
            ld         = 1'b1;
            ifid_pc    = pc - 64'd4;
            ifid_instr = skid;
            state_nxt  = REQ;
          end
        end
        DROP: begin
          if (accept) state_nxt = REQ;
        end
        default: state_nxt = REQ;
      endcase
    end
  end

  ifid_reg #(
    .NOP(NOP_INSTR)
  ) u_ifid (
    .clk    (clk),
    .reset  (reset),
    .en     (!stall_d || br_taken),
    .flush  (br_taken || !ld),
    .d_pc   (ifid_pc),
    .d_instr(ifid_instr),
    .d_valid(1'b1),
    .pc     (pc_d),
    .instr  (instr_d),
    .valid  (valid_d)
  );

endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of fetch and IF/ID.
module tb_fetch_ifid;

  localparam logic [31:0] NOP = 32'h8B1F03FF;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack, stall_d, br_taken, valid_d;
  logic [63:0] imem_addr, br_target, pc_d;
  logic [31:0] imem_rdata, instr_d;

  logic        w_req, w_ack, w_valid;
  logic [63:0] w_addr, w_pcd;
  logic [31:0] w_rdata, w_instr;

  int checks = 0;
  int failures = 0;

  // model state: pc, a stale request being drained, a stalled word, IF/ID
  logic [63:0] m_pc, m_old, m_pcd;
  logic [31:0] m_buf, m_instr;
  bit          m_drop, m_buf_full, m_started, m_valid;

  always #5 clk = ~clk;

  fetch_ifid #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall_d(stall_d),
    .br_taken(br_taken), .br_target(br_target), .pc_d(pc_d),
    .instr_d(instr_d), .valid_d(valid_d)
  );

  fetch_ifid #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall_d(1'b0),
    .br_taken(1'b0), .br_target(64'h0), .pc_d(w_pcd),
    .instr_d(w_instr), .valid_d(w_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_old = 64'h0; m_drop = 0; m_buf_full = 0; m_started = 0;
    m_pcd = 64'h0; m_instr = NOP; m_valid = 0; m_buf = NOP;
  endtask

  // one clock edge of fetch behaviour, applied to the model
  task automatic model_step(input logic r, input logic a, input logic s, input logic b,
                            input logic [63:0] t, input logic [31:0] d);
    bit req, acc, nd;
    if (!r) begin
      model_reset();
      return;
    end
    req = m_started && !m_buf_full;
    acc = req && a;
    if (b) begin
      nd = req && !acc;
      if (nd && !m_drop) m_old = m_pc;
      m_drop = nd;
      m_pc = t & ~64'h3;
      m_buf_full = 0;
      m_valid = 0;
      m_instr = NOP;
    end else if (m_drop) begin
      if (acc) m_drop = 0;
      m_valid = 0;
      m_instr = NOP;
    end else if (m_buf_full) begin
      if (!s) begin
        m_pcd = m_pc - 64'd4; m_instr = m_buf; m_valid = 1; m_buf_full = 0;
      end
    end else if (acc) begin
      if (s) begin
        m_buf = d; m_buf_full = 1;
      end else begin
        m_pcd = m_pc; m_instr = d; m_valid = 1;
      end
      m_pc = m_pc + 64'd4;
    end else if (!s) begin
      m_valid = 0;
      m_instr = NOP;
    end
    m_started = 1;
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".imem_req"}, {63'b0, imem_req}, {63'b0, m_started && !m_buf_full});
    chk({tag, ".imem_addr"}, imem_addr, m_drop ? m_old : m_pc);
    chk({tag, ".pc_d"}, pc_d, m_pcd);
    chk({tag, ".instr_d"}, {32'b0, instr_d}, {32'b0, m_instr});
    chk({tag, ".valid_d"}, {63'b0, valid_d}, {63'b0, m_valid});
  endtask

  // drive one cycle of inputs at the falling edge, then check after the next edge
  task automatic applyStimulus(input string tag, input logic r, input logic a, input logic s,
                               input logic b, input logic [63:0] t, input logic [31:0] d);
    reset = r; imem_ack = a; stall_d = s; br_taken = b; br_target = t; imem_rdata = d;
    model_step(r, a, s, b, t, d);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 0; stall_d = 0; br_taken = 0; br_target = 0; imem_rdata = 0;
    w_ack = 0; w_rdata = 32'hD503201F;
    model_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    applyStimulus("reset_hold", 0, 1, 0, 0, 64'h0, 32'h0);
    applyStimulus("release", 1, 0, 0, 0, 64'h0, 32'h0);

    applyStimulus("zw0", 1, 1, 0, 0, 64'h0, 32'h11111111);
    applyStimulus("zw1", 1, 1, 0, 0, 64'h0, 32'h22222222);
    applyStimulus("zw2", 1, 1, 0, 0, 64'h0, 32'h33333333);
    chk("zw_pc_d", pc_d, 64'h8);
    chk("zw_instr_d", {32'b0, instr_d}, 64'h33333333);

    applyStimulus("stall0", 1, 1, 1, 0, 64'h0, 32'hB0B0B0B0);
    applyStimulus("stall1", 1, 1, 1, 0, 64'h0, 32'hDEADBEEF);
    applyStimulus("stall2", 1, 1, 1, 0, 64'h0, 32'hDEADBEEF);
    chk("stall_req", {63'b0, imem_req}, 64'h0);
    applyStimulus("unstall", 1, 0, 0, 0, 64'h0, 32'h0);
    chk("unstall_instr", {32'b0, instr_d}, 64'hB0B0B0B0);
    chk("unstall_pc_d", pc_d, 64'hC);
    chk("unstall_addr", imem_addr, 64'h10);

    applyStimulus("redir0", 1, 0, 0, 1, 64'h103, 32'h0);
    chk("redir_addr_old", imem_addr, 64'h10);
    applyStimulus("redir1", 1, 0, 0, 0, 64'h0, 32'h0);
    applyStimulus("redir2", 1, 0, 0, 0, 64'h0, 32'h0);
    applyStimulus("redir_ack", 1, 1, 0, 0, 64'h0, 32'hBADBAD00);
    chk("redir_addr_new", imem_addr, 64'h100);
    chk("redir_valid", {63'b0, valid_d}, 64'h0);

    applyStimulus("brstall", 1, 1, 1, 1, 64'h200, 32'h44444444);
    chk("brstall_valid", {63'b0, valid_d}, 64'h0);
    chk("brstall_addr", imem_addr, 64'h200);

    chk("pre_reset_req", {63'b0, imem_req}, 64'h1);
    reset = 1'b0;
    #1;
    chk("async_req", {63'b0, imem_req}, 64'h0);
    chk("async_valid", {63'b0, valid_d}, 64'h0);
    chk("async_instr", {32'b0, instr_d}, {32'b0, NOP});
    model_reset();
    @(negedge clk);
    checkOutput("midreset");
    applyStimulus("midrelease", 1, 0, 0, 0, 64'h0, 32'h0);
    chk("midrelease_addr", imem_addr, 64'h0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", 1, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 8, {$urandom, $urandom}, $urandom);
    end

    chk("wrap_addr0", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req0", {63'b0, w_req}, 64'h1);
    w_ack = 1'b1;
    @(negedge clk);
    w_ack = 1'b0;
    chk("wrap_addr1", w_addr, 64'h0);
    chk("wrap_pc_d", w_pcd, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_valid", {63'b0, w_valid}, 64'h1);
    chk("wrap_instr", {32'b0, w_instr}, 64'hD503201F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
